// File: rtl/operand_loader.sv
// Loads two operands from debounced switch/button inputs and hands them off on a debounced "go".
// Action latency is DB_CYCLES+2 edges from raw press; a held button gives exactly one action.
module operand_loader #(
  parameter int SIZE      = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] sw_data,
  input  logic            sel,
  input  logic            btn_load,
  input  logic            btn_go,
  output logic [SIZE-1:0] op_a,
  output logic [SIZE-1:0] op_b,
  output logic            a_valid,
  output logic            b_valid,
  output logic            start,
  output logic            err,
  output logic            busy
);

  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_LOAD = 2'd1,
    DB_GO   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;

  logic            load_m_q, load_s;
  logic            go_m_q, go_s;
  logic            sel_m_q, sel_s;
  logic [SIZE-1:0] data_m_q, data_s;

  logic [SIZE-1:0] op_a_q, op_b_q;
  logic            a_valid_q, b_valid_q;
  logic            start_q, err_q;

  logic            db_btn;
  logic            last_sample;
  logic            do_load;
  logic            do_go;
  logic [31:0]     cnt_ext;

  // Two-flop synchronizers; everything downstream sees only the second stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_m_q <= 1'b0;
      load_s   <= 1'b0;
      go_m_q   <= 1'b0;
      go_s     <= 1'b0;
      sel_m_q  <= 1'b0;
      sel_s    <= 1'b0;
      data_m_q <= '0;
      data_s   <= '0;
    end else begin
      load_m_q <= btn_load;
      load_s   <= load_m_q;
      go_m_q   <= btn_go;
      go_s     <= go_m_q;
      sel_m_q  <= sel;
      sel_s    <= sel_m_q;
      data_m_q <= sw_data;
      data_s   <= data_m_q;
    end
  end

  // cnt_q counts samples already seen high; this edge's sample completes the run when cnt_q+1 reaches DB_CYCLES.
  always_comb begin
    db_btn      = (state_q == DB_GO) ? go_s : load_s;
    cnt_ext     = {{(32-CW){1'b0}}, cnt_q};
    last_sample = ((cnt_ext + 32'd1) >= 32'(DB_CYCLES));
    do_load     = 1'b0;
    do_go       = 1'b0;
    case (state_q)
      IDLE: begin
        if (DB_CYCLES == 1) begin
          do_load = load_s;
          do_go   = !load_s && go_s;
        end
      end
      DB_LOAD: do_load = load_s && last_sample;
      DB_GO:   do_go   = go_s && last_sample;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q <= do_go && a_valid_q && b_valid_q;
      err_q   <= do_go && !(a_valid_q && b_valid_q);

      // Operands are consumed the edge after the start pulse; values stay visible.
      if (start_q) begin
        a_valid_q <= 1'b0;
        b_valid_q <= 1'b0;
      end

      if (do_load) begin
        if (sel_s) begin
          op_b_q    <= data_s;
          b_valid_q <= 1'b1;
        end else begin
          op_a_q    <= data_s;
          a_valid_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (load_s || go_s) begin
            if (DB_CYCLES == 1) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
            end else begin
              state_q <= load_s ? DB_LOAD : DB_GO;
              cnt_q   <= CW'(1);
            end
          end
        end
        DB_LOAD, DB_GO: begin
          if (!db_btn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (last_sample) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!load_s && !go_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign start   = start_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, giving the debounce length in clock cycles (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port sw_data, input, SIZE bits, raw switch value to be loaded as an operand.
REQ-006 The block SHALL have port sel, input, 1 bit, raw slot select: 0 = operand A, 1 = operand B.
REQ-007 The block SHALL have port btn_load, input, 1 bit, raw load push-button, active-high.
REQ-008 The block SHALL have port btn_go, input, 1 bit, raw start push-button, active-high.
REQ-009 The block SHALL have port op_a, output, SIZE bits, registered operand A.
REQ-010 The block SHALL have port op_b, output, SIZE bits, registered operand B.
REQ-011 The block SHALL have port a_valid, output, 1 bit, set while op_a holds a loaded value.
REQ-012 The block SHALL have port b_valid, output, 1 bit, set while op_b holds a loaded value.
REQ-013 The block SHALL have port start, output, 1 bit, one-cycle pulse meaning both operands are handed to the consumer.
REQ-014 The block SHALL have port err, output, 1 bit, one-cycle pulse meaning go was pressed with an operand missing.
REQ-015 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-016 The block SHALL pass btn_load, btn_go, sel and sw_data each through a two-flop synchronizer; all logic uses only the second-stage values (load_s, go_s, sel_s, data_s).
REQ-017 The block SHALL implement FSM states IDLE, DB_LOAD, DB_GO, RELEASE, plus a debounce counter sized for DB_CYCLES.
REQ-018 In IDLE, load_s=1 SHALL move the FSM to DB_LOAD with count=1; otherwise go_s=1 SHALL move it to DB_GO with count=1 (load has priority); otherwise it stays in IDLE.
REQ-019 In DB_LOAD/DB_GO, if the debounced button's sync value is 0, the FSM SHALL return to IDLE with no action and the counter cleared.
REQ-020 In DB_LOAD/DB_GO, if the sync value is 1 and count<DB_CYCLES, the counter SHALL increment.
REQ-021 The action SHALL fire on the edge where the sync value has been sampled 1 on DB_CYCLES consecutive edges; the FSM then enters RELEASE (DB_CYCLES=1: action on the IDLE-exit edge, go to RELEASE directly).
REQ-022 Load action: if sel_s=0, op_a<=data_s and a_valid<=1; if sel_s=1, op_b<=data_s and b_valid<=1; an already-valid slot is overwritten and its valid stays 1.
REQ-023 Go action with a_valid=b_valid=1: start=1 for exactly that one cycle, with op_a/op_b held, and a_valid/b_valid cleared on the following edge while op_a/op_b keep their values.
REQ-024 Go action with either valid=0: err=1 for exactly one cycle; operands and valids unchanged; no start.
REQ-025 In RELEASE, the FSM SHALL return to IDLE only on an edge where load_s=0 and go_s=0; a held button SHALL never produce a second action.
REQ-026 start and err SHALL never be 1 in the same cycle, and at most one action SHALL occur per FSM pass.
REQ-027 Raw button to action latency SHALL be DB_CYCLES+2 rising edges (raw high before edge 0 -> outputs updated after edge DB_CYCLES+1).

Reset
REQ-028 rst=0 SHALL asynchronously force: FSM=IDLE, counter=0, all synchronizer flops=0, op_a=op_b=0, a_valid=b_valid=0, start=err=busy=0.
REQ-029 Reset asserted mid-debounce or mid-RELEASE SHALL abort the action with no partial update; after release, the block needs a fresh press.

Verification
REQ-030 Setup: DB_CYCLES=4, SIZE=4. Stimulus: sel=0, sw_data=4'hA, btn_load high 10 cycles. Required: op_a=4'hA and a_valid=1 after edge 5, busy until release, exactly one load.
REQ-031 Stimulus: btn_load glitch high for 3 cycles. Required: return to IDLE, no change to op_a/op_b/valids.
REQ-032 Stimulus: load A=4'h3, load B=4'h5, then press go. Required: start pulse 1 cycle with op_a=3, op_b=5; a_valid=b_valid=0 the next cycle.
REQ-033 Stimulus: after reset, load only B, then press go. Required: err pulse 1 cycle, no start, b_valid stays 1.
REQ-034 Stimulus: btn_load and btn_go rise on the same cycle. Required: load action only; go ignored until both buttons are released.
REQ-035 Stimulus: rst low during DB_GO with both operands valid. Required: all outputs 0 immediately, no start pulse.
